avg_unpool_unit: RTL and testbench

- Inverse of the average-pool stage: takes one pooled sample per window and expands it back to WINDOW output beats.
- Used on the backward/gradient path: MODE=1 distributes the pooled gradient evenly (value / WINDOW per beat); MODE=0 is nearest-neighbour upsampling (value replicated).
- Sits between the pooled-layer buffer (upstream valid/ready) and the layer-2 reconstruction path (downstream valid/ready).

---
 rtl/accel_pkg.sv | 18 +
 rtl/unpool_beat_counter.sv | 39 +++
 rtl/avg_unpool_unit.sv | 88 ++++++++
 tb/tb_avg_unpool_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default widths, pooling window, unpool
// mode encodings and the unpool FSM states.
package accel_pkg;

   localparam int ACCEL_DATA_W = 8;
   localparam int POOL_WINDOW  = 4;

   typedef enum logic {
      UNPOOL_REPLICATE = 1'b0,
      UNPOOL_DIVIDE    = 1'b1
   } unpool_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } unpool_state_e;

endpackage

// File: rtl/unpool_beat_counter.sv
// Modulo-WINDOW beat counter for unpooling units; only clear/increment move it,
// so it never wraps on its own.
module unpool_beat_counter #(
   parameter int WINDOW = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic incr,
   output logic is_last
);

   localparam int CW = $clog2(WINDOW);
   localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

   logic [CW-1:0] count_q, count_d;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (incr) begin
         count_d = count_q + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign is_last = (count_q == LAST_IDX);

endmodule

// File: rtl/avg_unpool_unit.sv
// Average-unpool: expands each accepted pooled sample into WINDOW output beats,
// either replicated or divided by WINDOW, with back-to-back window reload.
module avg_unpool_unit
   import accel_pkg::*;
#(
   parameter int DATA_W = ACCEL_DATA_W,
   parameter int WINDOW = POOL_WINDOW,
   parameter int MODE   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int SHIFT = $clog2(WINDOW);

   unpool_state_e     state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic [DATA_W-1:0] unpool_val;
   logic              cnt_clear, cnt_incr, cnt_last;
   logic              out_xfer, last_xfer, accept;

   assign out_valid = (state_q == EMIT);
   assign busy      = out_valid;
   assign out_last  = out_valid & cnt_last;
   assign out_data  = hold_q;

   assign out_xfer  = out_valid & out_ready;
   assign last_xfer = out_xfer & cnt_last;
   // In EMIT a new sample can only slip in on the final beat, giving 1 beat/cycle.
   assign in_ready  = ~rst & enable & ((state_q == IDLE) | last_xfer);
   assign accept    = in_valid & in_ready;

   // Arithmetic shift rounds toward -inf, matching the pooled-gradient convention.
   always_comb begin
      if (MODE == int'(UNPOOL_DIVIDE)) begin
         unpool_val = $signed(in_data) >>> SHIFT;
      end else begin
         unpool_val = in_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cnt_clear = 1'b0;
      cnt_incr  = 1'b0;
      if (accept) begin
         state_d   = EMIT;
         hold_d    = unpool_val;
         cnt_clear = 1'b1;
      end else if (last_xfer) begin
         state_d   = IDLE;
         cnt_clear = 1'b1;
      end else if (out_xfer) begin
         cnt_incr  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   unpool_beat_counter #(
      .WINDOW (WINDOW)
   ) u_beat_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .incr    (cnt_incr),
      .is_last (cnt_last)
   );

endmodule

// File: tb/tb_avg_unpool_unit.sv
// Directed bench for avg_unpool_unit: a divide-mode and a replicate-mode
// instance share the same stimulus and are checked against hand-computed values.
module tb_avg_unpool_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       d_in_ready, d_out_valid, d_out_last, d_busy;
   logic [7:0] d_out_data;
   logic       r_in_ready, r_out_valid, r_out_last, r_busy;
   logic [7:0] r_out_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   avg_unpool_unit #(.DATA_W(8), .WINDOW(4), .MODE(1)) u_div (
      .clk(clk), .rst(rst), .enable(enable),
      .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
      .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
      .out_last(d_out_last), .busy(d_busy)
   );

   avg_unpool_unit #(.DATA_W(8), .WINDOW(4), .MODE(0)) u_rep (
      .clk(clk), .rst(rst), .enable(enable),
      .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
      .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
      .out_last(r_out_last), .busy(r_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat checks shared by both instances; dv/rv are the divide/replicate values.
   task automatic check_beat(input string tag, input logic [7:0] dv, input logic [7:0] rv,
                             input logic last);
      check({tag, " d_valid"}, d_out_valid, 1'b1);
      check({tag, " r_valid"}, r_out_valid, 1'b1);
      check({tag, " d_data"},  d_out_data,  dv);
      check({tag, " r_data"},  r_out_data,  rv);
      check({tag, " d_last"},  d_out_last,  last);
      check({tag, " r_last"},  r_out_last,  last);
      check({tag, " busy"},    d_busy,      1'b1);
   endtask

   task automatic check_idle(input string tag);
      check({tag, " d_valid"}, d_out_valid, 1'b0);
      check({tag, " r_valid"}, r_out_valid, 1'b0);
      check({tag, " d_busy"},  d_busy,      1'b0);
      check({tag, " r_busy"},  r_busy,      1'b0);
   endtask

   task automatic accept(input string tag, input logic [7:0] data);
      in_valid = 1'b1;
      in_data  = data;
      #1;
      check({tag, " in_ready"}, d_in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic run_window(input string tag, input logic [7:0] dv, input logic [7:0] rv);
      for (int k = 0; k < 4; k++) begin
         #1;
         check_beat($sformatf("%s beat%0d", tag, k), dv, rv, k == 3);
         if (k < 3) check($sformatf("%s beat%0d in_ready", tag, k), d_in_ready, 1'b0);
         tick();
      end
      #1;
      check_idle({tag, " end"});
   endtask

   initial begin
      int xfers;
      logic [6:0] bp_pattern;

      rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

      // Reset: two cycles, in_ready low while rst is high.
      tick();
      check("reset in_ready", d_in_ready, 1'b0);
      tick();
      check_idle("reset");
      check("reset d_data", d_out_data, 8'h00);
      check("reset r_data", r_out_data, 8'h00);
      rst = 1'b0;
      #1;
      check("post-reset in_ready", d_in_ready, 1'b1);

      // +20: divide gives +5, replicate +20.
      accept("pos20", 8'd20);
      run_window("pos20", 8'd5, 8'd20);

      // -5: divide rounds toward -inf to -2.
      accept("neg5", 8'hFB);
      run_window("neg5", 8'hFE, 8'hFB);

      // -128 then 0x7F back-to-back on the last beat: 8 beats, no gap.
      accept("b2b", 8'h80);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            in_valid = 1'b1;
            in_data  = 8'h7F;
         end
         #1;
         check_beat($sformatf("b2b beat%0d", i),
                    (i < 4) ? 8'hE0 : 8'h1F, (i < 4) ? 8'h80 : 8'h7F, (i == 3) || (i == 7));
         if (i == 3) check("b2b reload in_ready", d_in_ready, 1'b1);
         tick();
         if (i == 3) in_valid = 1'b0;
      end
      #1;
      check_idle("b2b end");

      // Backpressure 1,0,0,1,0,1,1 on a +40 window (divide value 10).
      accept("bp", 8'd40);
      bp_pattern = 7'b1101001;  // bit i is out_ready on cycle i
      xfers = 0;
      for (int i = 0; i < 7; i++) begin
         out_ready = bp_pattern[i];
         #1;
         check_beat($sformatf("bp cyc%0d", i), 8'd10, 8'd40, xfers == 3);
         if (bp_pattern[i]) xfers++;
         tick();
      end
      out_ready = 1'b1;
      check("bp transfers", xfers, 4);
      #1;
      check_idle("bp end");

      // enable low in IDLE blocks acceptance.
      enable = 1'b0; in_valid = 1'b1; in_data = 8'd8;
      #1;
      check("en0 idle in_ready", d_in_ready, 1'b0);
      tick();
      #1;
      check_idle("en0 idle");

      // Accept with enable, then drop it: window still completes, no reload.
      enable = 1'b1;
      #1;
      check("en1 in_ready", d_in_ready, 1'b1);
      tick();
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_beat($sformatf("endrop beat%0d", k), 8'd2, 8'd8, k == 3);
         check($sformatf("endrop beat%0d in_ready", k), d_in_ready, 1'b0);
         tick();
      end
      #1;
      check_idle("endrop end");
      check("endrop idle in_ready", d_in_ready, 1'b0);
      tick();
      #1;
      check_idle("endrop held");
      in_valid = 1'b0; enable = 1'b1;
      accept("en-restore", 8'd12);
      run_window("en-restore", 8'd3, 8'd12);

      // Reset after two beats drops the window; next window starts at count 0.
      accept("rstmid", 8'd100);
      for (int k = 0; k < 2; k++) begin
         #1;
         check_beat($sformatf("rstmid beat%0d", k), 8'd25, 8'd100, 1'b0);
         tick();
      end
      rst = 1'b1;
      #1;
      check("rstmid in_ready", d_in_ready, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check_idle("rstmid after");
      check("rstmid data", d_out_data, 8'h00);
      accept("fresh", 8'hF0);
      run_window("fresh", 8'hFC, 8'hF0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
